reabastecedor_rolhas: RTL

Cork-stock supplier that sits on the far end of the tray's refill interface. It watches the tray's status flags CR (five corks left) and BZ (zero corks left) and issues a one-cycle `reabastecer` pulse that adds a 20-cork lot to the tray. Each lot is debited from a two-digit BCD warehouse stock. An interlock guarantees exactly one lot per low-stock event, and an `EV` flag reports when the stock can no longer cover a lot.

---
 rtl/rolhas_pkg.sv | 17 +
 rtl/estoque_bcd.sv | 48 ++++
 rtl/reabastecedor_rolhas.sv | 78 +++++++
 3 files changed

// File: rtl/rolhas_pkg.sv
// Shared definitions for the cork-stock supplier: FSM encoding,
// default lot size and BCD digit width.
package rolhas_pkg;

    localparam int DIGITO_W = 4;

    // A lot is counted in whole tens of corks.
    localparam logic [3:0] LOTE_PADRAO_DEZENAS = 4'd2;
    localparam int         LOTE_PADRAO_ROLHAS  = 20;

    typedef enum logic [1:0] {
        ESPERA = 2'b00,
        PULSO  = 2'b01,
        TRAVA  = 2'b10
    } estado_t;

endpackage

// File: rtl/estoque_bcd.sv
// Two-digit BCD warehouse stock with reload and tens-only debit.
module estoque_bcd
    import rolhas_pkg::*;
#(
    parameter logic [7:0] INICIAL = 8'h99,
    parameter logic [3:0] N       = LOTE_PADRAO_DEZENAS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                debita,
    output logic [DIGITO_W-1:0] dezenas,
    output logic [DIGITO_W-1:0] unidades,
    output logic                insuficiente
);

    logic [DIGITO_W-1:0] dezenas_d;
    logic [DIGITO_W-1:0] dezenas_q;
    logic [DIGITO_W-1:0] unidades_d;
    logic [DIGITO_W-1:0] unidades_q;

    // Reload wins over a debit on the same edge.
    always_comb begin
        dezenas_d  = dezenas_q;
        unidades_d = unidades_q;
        if (load) begin
            dezenas_d  = INICIAL[7:4];
            unidades_d = INICIAL[3:0];
        end else if (debita) begin
            dezenas_d = dezenas_q - N;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dezenas_q  <= INICIAL[7:4];
            unidades_q <= INICIAL[3:0];
        end else begin
            dezenas_q  <= dezenas_d;
            unidades_q <= unidades_d;
        end
    end

    assign dezenas      = dezenas_q;
    assign unidades     = unidades_q;
    assign insuficiente = (dezenas_q < N);

endmodule

// File: rtl/reabastecedor_rolhas.sv
// Tray refill supplier: one 20-cork lot per low-stock event,
// debited from a BCD stock, with an interlock until the tray refills.
module reabastecedor_rolhas
    import rolhas_pkg::*;
#(
    parameter logic [7:0] ESTOQUE_INICIAL = 8'h99,
    parameter logic [3:0] LOTE_DEZENAS    = LOTE_PADRAO_DEZENAS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                CR,
    input  logic                BZ,
    input  logic                recarga,
    output logic                reabastecer,
    output logic                EV,
    output logic [DIGITO_W-1:0] unidades_estoque,
    output logic [DIGITO_W-1:0] dezenas_estoque,
    output logic [3:0]          lotes
);

    estado_t    state_d;
    estado_t    state_q;
    logic       reab_d;
    logic       reab_q;
    logic [3:0] lotes_d;
    logic [3:0] lotes_q;
    logic       ev;
    logic       debita;

    assign debita = (state_q == PULSO);

    estoque_bcd #(
        .INICIAL (ESTOQUE_INICIAL),
        .N       (LOTE_DEZENAS)
    ) u_estoque (
        .clk          (clk),
        .reset        (reset),
        .load         (recarga),
        .debita       (debita),
        .dezenas      (dezenas_estoque),
        .unidades     (unidades_estoque),
        .insuficiente (ev)
    );

    // A pending request is held off while the stock cannot cover a lot.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ESPERA:  if ((CR | BZ) & ~ev) state_d = PULSO;
            PULSO:   state_d = TRAVA;
            TRAVA:   if (!CR && !BZ) state_d = ESPERA;
            default: state_d = ESPERA;
        endcase
    end

    always_comb begin
        lotes_d = lotes_q;
        if (debita) lotes_d = lotes_q + 4'd1;
        reab_d = (state_d == PULSO);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ESPERA;
            reab_q  <= 1'b0;
            lotes_q <= 4'd0;
        end else begin
            state_q <= state_d;
            reab_q  <= reab_d;
            lotes_q <= lotes_d;
        end
    end

    assign reabastecer = reab_q;
    assign EV          = ev;
    assign lotes       = lotes_q;

endmodule
